// File: rtl/skew_tile_feeder_pkg.sv
// Shared types and sizing helpers for the skewed tile feeder.
package skew_tile_feeder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Cycles per tile iteration: 2N-1 feed beats, one settle beat, DRAIN idle beats,
    // and the release beat.
    function automatic int tile_period(input int n, input int drain);
        return 2 * n + 1 + drain;
    endfunction

    // Address/counter width for a range of `depth` values, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the tiles-per-dimension input; one extra bit so TILES itself fits.
    function automatic int tpd_w(input int tiles);
        return $clog2(tiles) + 1;
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Per-lane read address and valid generator for one operand bank.
// Lane k is active while d = counter - k lies in 0..N-1 and reads base + k*N + d.
module skew_lane_mux
    import skew_tile_feeder_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 6,
    parameter int CW = 4
) (
    input  logic [CW-1:0]   counter,
    input  logic [AW-1:0]   base,
    input  logic            en,
    output logic [N*AW-1:0] lane_addr,
    output logic [N-1:0]    lane_valid
);

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [CW-1:0] d;
        // Wraps when counter < k; the valid term masks that case.
        assign d = counter - CW'(k);
        assign lane_valid[k] = en && (counter >= CW'(k)) && (d < CW'(N));
        assign lane_addr[k*AW +: AW] = base + AW'(k * N) + AW'(d);
    end

endmodule

// File: rtl/skew_tile_feeder.sv
// Operand store and diagonal wavefront feeder for an N x N systolic array.
// Optional build macro: SKEW_TILE_FEEDER_OUT_REG_EN adds one output register stage
// on data/valids and delays clear, release_output and mem_done to match.
module skew_tile_feeder
    import skew_tile_feeder_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int TILES = 4,
    parameter int DRAIN = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic                              wr_sel,
    input  logic [addr_w(TILES*N*N)-1:0]      wr_addr,
    input  logic signed [DW-1:0]              wr_data,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              hold,
    input  logic [tpd_w(TILES)-1:0]           tpd,
    output logic [N*DW-1:0]                   a_data,
    output logic [N-1:0]                      a_valid,
    output logic [N*DW-1:0]                   b_data,
    output logic [N-1:0]                      b_valid,
    output logic                              busy,
    output logic                              clear,
    output logic                              release_output,
    output logic                              mem_done,
    output logic [addr_w(TILES*TILES)-1:0]    iter,
    output logic                              wr_err,
    output logic                              cfg_err
);

    localparam int DEPTH = TILES * N * N;
    localparam int AW    = addr_w(DEPTH);
    localparam int TW    = tpd_w(TILES);
    localparam int IW    = addr_w(TILES * TILES);
    localparam int P     = tile_period(N, DRAIN);
    localparam int CW    = addr_w(P);
    localparam logic [CW-1:0] CNT_END = CW'(P - 1);
    localparam logic [CW-1:0] CNT_ADV = CW'(P - 2);

    state_t               state;
    logic [CW-1:0]        counter;
    logic [IW-1:0]        iter_q;
    logic [TW-1:0]        a_tile;
    logic [TW-1:0]        b_tile;
    logic [TW-1:0]        tile_max;
    logic                 clear_q;
    logic                 mem_done_q;
    logic                 wr_err_q;
    logic                 cfg_err_q;

    logic signed [DW-1:0] bank_a [DEPTH];
    logic signed [DW-1:0] bank_b [DEPTH];

    logic                 run;
    logic                 feed_en;
    logic                 last_iter;
    logic [AW-1:0]        base_a;
    logic [AW-1:0]        base_b;
    logic [N*AW-1:0]      a_addr;
    logic [N*AW-1:0]      b_addr;
    logic [N-1:0]         a_lane_vld;
    logic [N-1:0]         b_lane_vld;
    logic [N*DW-1:0]      a_data_c;
    logic [N*DW-1:0]      b_data_c;
    logic                 release_c;

    assign run       = (state == RUN);
    assign feed_en   = run && !hold;
    // a_tile/b_tile track iter / tpd and iter % tpd without a divider.
    assign last_iter = (a_tile == tile_max) && (b_tile == tile_max);
    assign base_a    = AW'(a_tile) * AW'(N * N);
    assign base_b    = AW'(b_tile) * AW'(N * N);
    assign release_c = run && (counter == CNT_END);

    // Run control: tile counter, iteration/tile indices and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            iter_q     <= '0;
            a_tile     <= '0;
            b_tile     <= '0;
            tile_max   <= '0;
            clear_q    <= 1'b0;
            mem_done_q <= 1'b0;
            wr_err_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            wr_err_q  <= wr_en && run;
            if (stop) begin
                state      <= IDLE;
                counter    <= '0;
                iter_q     <= '0;
                a_tile     <= '0;
                b_tile     <= '0;
                clear_q    <= 1'b0;
                mem_done_q <= 1'b0;
            end else if (!run) begin
                clear_q    <= 1'b0;
                mem_done_q <= 1'b0;
                if (start) begin
                    state   <= RUN;
                    counter <= '0;
                    iter_q  <= '0;
                    a_tile  <= '0;
                    b_tile  <= '0;
                    if ((tpd == '0) || (tpd > TW'(TILES))) begin
                        tile_max  <= '0;
                        cfg_err_q <= 1'b1;
                    end else begin
                        tile_max <= tpd - TW'(1);
                    end
                end
            end else if (!hold) begin
                clear_q    <= 1'b0;
                mem_done_q <= 1'b0;
                if (counter == CNT_END) begin
                    counter <= '0;
                    // iter already advanced at P-2; zero here means the last tile just ended.
                    if (iter_q == '0) begin
                        state <= IDLE;
                    end
                end else begin
                    counter <= counter + CW'(1);
                end
                if (counter == CNT_ADV) begin
                    clear_q    <= 1'b1;
                    mem_done_q <= last_iter;
                    if (last_iter) begin
                        iter_q <= '0;
                        a_tile <= '0;
                        b_tile <= '0;
                    end else begin
                        iter_q <= iter_q + IW'(1);
                        if (b_tile == tile_max) begin
                            b_tile <= '0;
                            a_tile <= a_tile + TW'(1);
                        end else begin
                            b_tile <= b_tile + TW'(1);
                        end
                    end
                end
            end
        end
    end

    // Host writes land only while idle; banks clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (wr_en && !run) begin
            if (wr_sel) begin
                bank_b[wr_addr] <= wr_data;
            end else begin
                bank_a[wr_addr] <= wr_data;
            end
        end
    end

    skew_lane_mux #(.N(N), .AW(AW), .CW(CW)) u_lane_a (
        .counter    (counter),
        .base       (base_a),
        .en         (feed_en),
        .lane_addr  (a_addr),
        .lane_valid (a_lane_vld)
    );

    skew_lane_mux #(.N(N), .AW(AW), .CW(CW)) u_lane_b (
        .counter    (counter),
        .base       (base_b),
        .en         (feed_en),
        .lane_addr  (b_addr),
        .lane_valid (b_lane_vld)
    );

    // Lane data reads; inactive lanes are driven to zero.
    always_comb begin
        a_data_c = '0;
        b_data_c = '0;
        for (int k = 0; k < N; k++) begin
            if (a_lane_vld[k]) begin
                a_data_c[k*DW +: DW] = bank_a[a_addr[k*AW +: AW]];
            end
            if (b_lane_vld[k]) begin
                b_data_c[k*DW +: DW] = bank_b[b_addr[k*AW +: AW]];
            end
        end
    end

`ifdef SKEW_TILE_FEEDER_OUT_REG_EN
    // Output stage p1: data, valids and array strobes move together; a stall freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data         <= '0;
            a_valid        <= '0;
            b_data         <= '0;
            b_valid        <= '0;
            clear          <= 1'b0;
            release_output <= 1'b0;
            mem_done       <= 1'b0;
        end else if (!(run && hold)) begin
            a_data         <= a_data_c;
            a_valid        <= a_lane_vld;
            b_data         <= b_data_c;
            b_valid        <= b_lane_vld;
            clear          <= clear_q;
            release_output <= release_c;
            mem_done       <= mem_done_q;
        end
    end
`else
    assign a_data         = a_data_c;
    assign a_valid        = a_lane_vld;
    assign b_data         = b_data_c;
    assign b_valid        = b_lane_vld;
    assign clear          = clear_q;
    assign release_output = release_c;
    assign mem_done       = mem_done_q;
`endif

    assign busy    = run;
    assign iter    = iter_q;
    assign wr_err  = wr_err_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_skew_tile_feeder.sv
// Self-checking bench for skew_tile_feeder at N=4, DW=16, TILES=4, DRAIN=2.
module tb_skew_tile_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        hold = 1'b0;
    logic [2:0]  tpd = '0;
    logic [63:0] a_data;
    logic [3:0]  a_valid;
    logic [63:0] b_data;
    logic [3:0]  b_valid;
    logic        busy;
    logic        clear;
    logic        release_output;
    logic        mem_done;
    logic [3:0]  iter;
    logic        wr_err;
    logic        cfg_err;

    skew_tile_feeder #(.N(4), .DW(16), .TILES(4), .DRAIN(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .stop           (stop),
        .hold           (hold),
        .tpd            (tpd),
        .a_data         (a_data),
        .a_valid        (a_valid),
        .b_data         (b_data),
        .b_valid        (b_valid),
        .busy           (busy),
        .clear          (clear),
        .release_output (release_output),
        .mem_done       (mem_done),
        .iter           (iter),
        .wr_err         (wr_err),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  av;
        logic [3:0]  bv;
        logic        busy;
        logic        clr;
        logic        rel;
        logic        done;
        logic        werr;
        logic        cerr;
        logic [3:0]  it;
    } exp_t;

    typedef struct packed {
        logic hold;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t vtab [11];
    int   ma [64];
    int   mb [64];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s cycle %0d: got %h expected %h", tag, name, cyc, act, exp);
        end
    endtask

    task automatic cmp(input exp_t e, input string tag);
        chk(tag, "a_data", a_data, e.a);
        chk(tag, "b_data", b_data, e.b);
        chk(tag, "a_valid", 64'(a_valid), 64'(e.av));
        chk(tag, "b_valid", 64'(b_valid), 64'(e.bv));
        chk(tag, "busy", 64'(busy), 64'(e.busy));
        chk(tag, "clear", 64'(clear), 64'(e.clr));
        chk(tag, "release_output", 64'(release_output), 64'(e.rel));
        chk(tag, "mem_done", 64'(mem_done), 64'(e.done));
        chk(tag, "iter", 64'(iter), 64'(e.it));
        chk(tag, "wr_err", 64'(wr_err), 64'(e.werr));
        chk(tag, "cfg_err", 64'(cfg_err), 64'(e.cerr));
    endtask

    // Inputs are already set for this cycle; expectation goes through the scoreboard.
    task automatic step(input exp_t e, input string tag);
        exp_t got;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        cmp(got, tag);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input logic [3:0] v, input logic last);
        exp_t e = '0;
        e.busy = 1'b1;
        e.a    = a;
        e.b    = b;
        e.av   = v;
        e.bv   = v;
        e.clr  = last;
        e.rel  = last;
        e.done = last;
        return e;
    endfunction

    // Reference: iteration `it`, beat `c` of an 11-cycle tile, tp tiles per dimension.
    function automatic exp_t model(input int it, input int c, input int tp, input logic hd);
        exp_t e = '0;
        int ta = it / tp;
        int tb = it % tp;
        e.busy = 1'b1;
        if (!hd) begin
            for (int k = 0; k < 4; k++) begin
                int d = c - k;
                if (d >= 0 && d < 4) begin
                    e.av[k] = 1'b1;
                    e.bv[k] = 1'b1;
                    e.a[k*16 +: 16] = 16'(ma[ta*16 + k*4 + d]);
                    e.b[k*16 +: 16] = 16'(mb[tb*16 + k*4 + d]);
                end
            end
        end
        e.rel  = (c == 10);
        e.clr  = (c == 10);
        e.done = (c == 10) && (it == tp*tp - 1);
        e.it   = 4'((c == 10) ? (it + 1) % (tp*tp) : it);
        return e;
    endfunction

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 6'(addr);
        wr_data = 16'(data);
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
        step('0, "load");
        wr_en = 1'b0;
    endtask

    // Full or aborted run. probe adds a rejected write and an ignored start mid-run.
    task automatic run(input int tp_in, input int tp, input int hold_c, input int hold_n,
                       input int stop_it, input int stop_c, input logic probe, input string tag);
        exp_t e;
        logic stopped = 1'b0;
        logic wr_pend = 1'b0;
        start = 1'b1;
        tpd   = 3'(tp_in);
        step('0, tag);
        start = 1'b0;
        for (int it = 0; it < tp*tp && !stopped; it++) begin
            for (int c = 0; c < 11 && !stopped; c++) begin
                int reps;
                reps = (it == 0 && c == hold_c) ? hold_n : 0;
                for (int h = 0; h <= reps; h++) begin
                    hold = (h < reps);
                    e = model(it, c, tp, hold);
                    e.cerr = (it == 0 && c == 0 && h == 0) && (tp_in == 0 || tp_in > 4);
                    e.werr = wr_pend;
                    wr_pend = 1'b0;
                    if (probe && it == 0 && c == 3) begin
                        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 16'h7777;
                        wr_pend = 1'b1;
                    end
                    if (probe && it == 2 && c == 1) begin
                        start = 1'b1; tpd = 3'd1;
                    end
                    if (it == stop_it && c == stop_c) begin
                        stop = 1'b1;
                        stopped = 1'b1;
                    end
                    step(e, tag);
                    wr_en = 1'b0;
                    start = 1'b0;
                    stop  = 1'b0;
                end
            end
        end
        hold = 1'b0;
        step('0, tag);
        step('0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got timeout expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        // Single-tile run: A = identity, B = 1..16, expected per counter value.
        vtab[0]  = {1'b0, mk({16'd0, 16'd0, 16'd0, 16'd1}, {16'd0,  16'd0,  16'd0, 16'd1}, 4'b0001, 1'b0)};
        vtab[1]  = {1'b0, mk(64'd0,                      {16'd0,  16'd0,  16'd5, 16'd2}, 4'b0011, 1'b0)};
        vtab[2]  = {1'b0, mk({16'd0, 16'd0, 16'd1, 16'd0}, {16'd0,  16'd9,  16'd6, 16'd3}, 4'b0111, 1'b0)};
        vtab[3]  = {1'b0, mk(64'd0,                      {16'd13, 16'd10, 16'd7, 16'd4}, 4'b1111, 1'b0)};
        vtab[4]  = {1'b0, mk({16'd0, 16'd1, 16'd0, 16'd0}, {16'd14, 16'd11, 16'd8, 16'd0}, 4'b1110, 1'b0)};
        vtab[5]  = {1'b0, mk(64'd0,                      {16'd15, 16'd12, 16'd0, 16'd0}, 4'b1100, 1'b0)};
        vtab[6]  = {1'b0, mk({16'd1, 16'd0, 16'd0, 16'd0}, {16'd16, 16'd0,  16'd0, 16'd0}, 4'b1000, 1'b0)};
        vtab[7]  = {1'b0, mk(64'd0, 64'd0, 4'b0000, 1'b0)};
        vtab[8]  = {1'b0, mk(64'd0, 64'd0, 4'b0000, 1'b0)};
        vtab[9]  = {1'b0, mk(64'd0, 64'd0, 4'b0000, 1'b0)};
        vtab[10] = {1'b0, mk(64'd0, 64'd0, 4'b0000, 1'b1)};

        repeat (2) @(posedge clk);
        #1;
        step('0, "reset");
        rst = 1'b0;
        step('0, "post_reset");

        for (int r = 0; r < 4; r++) wr(1'b0, r*4 + r, 1);
        for (int i = 0; i < 16; i++) wr(1'b1, i, i + 1);

        start = 1'b1;
        tpd   = 3'd1;
        step('0, "t1_start");
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            hold = vtab[i].hold;
            step(vtab[i].e, "t1_table");
        end
        hold = 1'b0;
        step('0, "t1_end");

        run(1, 1, 2, 3, -1, -1, 1'b0, "hold");
        run(5, 1, -1, 0, -1, -1, 1'b0, "cfg");

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 16; i++) begin
                wr(1'b0, t*16 + i, 10*t + i);
                wr(1'b1, t*16 + i, 200 + 16*t + i);
            end
        end
        run(2, 2, -1, 0, -1, -1, 1'b1, "tpd2");
        run(2, 2, -1, 0, 1, 5, 1'b0, "stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
